// File: rtl/icosoc_mod_gpio_irq_pkg.sv
// Register map and parameter limits shared by the icosoc GPIO peripheral.
// Combinational constants only: no latency, no flow control.
package icosoc_gpio_pkg;
  localparam logic [7:0] GPIO_DATA    = 8'h00;
  localparam logic [7:0] GPIO_DIR     = 8'h04;
  localparam logic [7:0] GPIO_SET     = 8'h08;
  localparam logic [7:0] GPIO_CLR     = 8'h0C;
  localparam logic [7:0] GPIO_TGL     = 8'h10;
  localparam logic [7:0] GPIO_RISE_EN = 8'h14;
  localparam logic [7:0] GPIO_FALL_EN = 8'h18;
  localparam logic [7:0] GPIO_STATUS  = 8'h1C;
  localparam logic [7:0] GPIO_OUT     = 8'h20;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int IO_LENGTH_MAX   = 32;
endpackage

// File: rtl/icosoc_mod_gpio_irq_if.sv
// icosoc control bus: request held until a one-cycle ctrl_done pulse.
// Completion one cycle after the request is seen; no further backpressure.
interface icosoc_mod_gpio_irq_if;
  logic        ctrl_wr;
  logic        ctrl_rd;
  logic [7:0]  ctrl_addr;
  logic [31:0] ctrl_wdat;
  logic [31:0] ctrl_rdat;
  logic        ctrl_done;

  modport master (output ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
                  input  ctrl_rdat, ctrl_done);
  modport slave  (input  ctrl_wr, ctrl_rd, ctrl_addr, ctrl_wdat,
                  output ctrl_rdat, ctrl_done);
endinterface

// File: rtl/icosoc_mod_gpio_irq_edge.sv
// Pin synchroniser plus per-pin rise/fall detection, gated off while the chain fills.
// sync lags the pin by SYNC_STAGES cycles; rise/fall are combinational from sync/prev.
module icosoc_gpio_edge #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pin,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  localparam int ARM_CYCLES = SYNC_STAGES + 1;
  localparam int CW         = $clog2(ARM_CYCLES + 1);

  logic [WIDTH-1:0] chain [SYNC_STAGES];
  logic [WIDTH-1:0] prev;
  logic [CW-1:0]    arm_cnt;
  logic             armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) chain[i] <= '0;
      prev    <= '0;
      arm_cnt <= '0;
    end else begin
      chain[0] <= pin;
      for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      prev <= sync;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end
  end

  // The reset-zeroed chain would otherwise report a bogus rise on every pin held high.
  assign armed = (arm_cnt == CW'(ARM_CYCLES));
  assign sync  = chain[SYNC_STAGES-1];
  assign rise  = sync & ~prev & rise_en & {WIDTH{armed}};
  assign fall  = ~sync & prev & fall_en & {WIDTH{armed}};
endmodule

// File: rtl/icosoc_mod_gpio_irq.sv
// icosoc GPIO with set/clr/toggle, sticky edge status (W1C) and a level irq.
// Access completes one cycle after the request; irq is registered from STATUS.
module icosoc_mod_gpio_irq
  import icosoc_gpio_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ = 0,
  parameter int IO_LENGTH     = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  icosoc_mod_gpio_irq_if.slave ctrl,
  inout  wire [IO_LENGTH-1:0]  IO,
  output logic                 irq
);
  if (IO_LENGTH < 1 || IO_LENGTH > IO_LENGTH_MAX || SYNC_STAGES < SYNC_STAGES_MIN ||
      SYNC_STAGES > SYNC_STAGES_MAX || CLOCK_FREQ_HZ < 0) begin : g_bad_params
    $error("icosoc_mod_gpio_irq: illegal parameter value");
  end

  logic [IO_LENGTH-1:0] out, dir, rise_en, fall_en, status;
  logic [IO_LENGTH-1:0] pin_in, sync, rise, fall, wd, w1c;
  logic [31:0]          rd_val;
  logic                 start, wr_hit;

  // Per-pin tristate pad: SB_IO PIN_TYPE 6'b1010_01, no pull-up, inferred from this form.
  for (genvar i = 0; i < IO_LENGTH; i++) begin : g_pad
    assign IO[i] = dir[i] ? out[i] : 1'bz;
  end
  assign pin_in = IO;

  icosoc_gpio_edge #(.WIDTH(IO_LENGTH), .SYNC_STAGES(SYNC_STAGES)) u_edge (
    .clk     (clk),
    .reset   (reset),
    .pin     (pin_in),
    .rise_en (rise_en),
    .fall_en (fall_en),
    .sync    (sync),
    .rise    (rise),
    .fall    (fall)
  );

  assign start  = (ctrl.ctrl_wr | ctrl.ctrl_rd) & ~ctrl.ctrl_done;
  assign wr_hit = start & ctrl.ctrl_wr;
  assign wd     = ctrl.ctrl_wdat[IO_LENGTH-1:0];
  assign w1c    = (wr_hit && ctrl.ctrl_addr == GPIO_STATUS) ? wd : '0;

  always_comb begin
    rd_val = '0;
    case (ctrl.ctrl_addr)
      GPIO_DATA:                               rd_val[IO_LENGTH-1:0] = sync;
      GPIO_DIR:                                rd_val[IO_LENGTH-1:0] = dir;
      GPIO_SET, GPIO_CLR, GPIO_TGL, GPIO_OUT:  rd_val[IO_LENGTH-1:0] = out;
      GPIO_RISE_EN:                            rd_val[IO_LENGTH-1:0] = rise_en;
      GPIO_FALL_EN:                            rd_val[IO_LENGTH-1:0] = fall_en;
      GPIO_STATUS:                             rd_val[IO_LENGTH-1:0] = status;
      default:                                 rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl.ctrl_done <= 1'b0;
      ctrl.ctrl_rdat <= '0;
      out            <= '0;
      dir            <= '0;
      rise_en        <= '0;
      fall_en        <= '0;
      status         <= '0;
      irq            <= 1'b0;
    end else begin
      ctrl.ctrl_done <= start;
      // rd_val is sampled before this edge's write, so wr+rd returns the old value.
      ctrl.ctrl_rdat <= (start && ctrl.ctrl_rd) ? rd_val : '0;
      if (wr_hit) begin
        case (ctrl.ctrl_addr)
          GPIO_DATA:    out     <= wd;
          GPIO_DIR:     dir     <= wd;
          GPIO_SET:     out     <= out | wd;
          GPIO_CLR:     out     <= out & ~wd;
          GPIO_TGL:     out     <= out ^ wd;
          GPIO_RISE_EN: rise_en <= wd;
          GPIO_FALL_EN: fall_en <= wd;
          default: ;
        endcase
      end
      // New edges are OR-ed in after the clear so a coincident event survives.
      status <= (status & ~w1c) | rise | fall;
      irq    <= |status;
    end
  end
endmodule

// File: tb/tb_icosoc_mod_gpio_irq.sv
module tb_icosoc_mod_gpio_irq;
  import icosoc_gpio_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic irq;
  logic [7:0] tb_en, tb_drv;
  wire  [7:0] pins;

  always #5 clk = ~clk;

  icosoc_mod_gpio_irq_if bus ();

  for (genvar i = 0; i < 8; i++) begin : g_tbdrv
    assign pins[i] = tb_en[i] ? tb_drv[i] : 1'bz;
  end

  icosoc_mod_gpio_irq #(.CLOCK_FREQ_HZ(0), .IO_LENGTH(8), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus),
    .IO    (pins),
    .irq   (irq)
  );

  typedef struct {
    logic        chk;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int n_vec = 0, n_miss = 0, n_push = 0, n_done = 0;

  // Monitor: every ctrl_done pops one expectation; reads compare ctrl_rdat.
  initial begin : monitor
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ctrl_done === 1'b1) begin
        n_done++;
        n_vec++;
        if (prev_done !== 1'b0) begin
          n_miss++;
          $display("FAIL done_width: ctrl_done high two cycles in a row");
        end
        if (sb.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_done: rdat=%h with no access pending", bus.ctrl_rdat);
        end else begin
          e = sb.pop_front();
          if (e.chk) begin
            n_vec++;
            if (bus.ctrl_rdat !== e.val) begin
              n_miss++;
              $display("FAIL %s: rdat=%h expected=%h", e.name, bus.ctrl_rdat, e.val);
            end
          end
        end
      end
      prev_done = bus.ctrl_done;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got=%h expected=%h", nm, act, exp);
    end
  endtask

  // Call at a negedge; returns at the negedge where ctrl_done is seen.
  task automatic acc(input logic w, input logic r, input logic [7:0] a, input logic [31:0] d,
                     input logic c, input logic [31:0] ev, input string nm);
    logic got;
    sb.push_back('{c, ev, nm});
    n_push++;
    bus.ctrl_wr = w; bus.ctrl_rd = r; bus.ctrl_addr = a; bus.ctrl_wdat = d;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = bus.ctrl_done;
    end
    if (!got) begin
      n_vec++;
      n_miss++;
      $display("FAIL %s_timeout: no ctrl_done within 20 cycles", nm);
    end
    bus.ctrl_wr = 1'b0; bus.ctrl_rd = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input string nm);
    acc(1'b1, 1'b0, a, d, 1'b0, 32'h0, nm);
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] ev, input string nm);
    acc(1'b0, 1'b1, a, 32'h0, 1'b1, ev, nm);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] addrs [10];
    addrs = '{GPIO_DATA, GPIO_DIR, GPIO_SET, GPIO_CLR, GPIO_TGL,
              GPIO_RISE_EN, GPIO_FALL_EN, GPIO_STATUS, GPIO_OUT, 8'h40};
    reset = 1'b1; tb_en = 8'hFF; tb_drv = 8'h00;
    bus.ctrl_wr = 1'b0; bus.ctrl_rd = 1'b0; bus.ctrl_addr = '0; bus.ctrl_wdat = '0;
    repeat (3) @(negedge clk);
    chk("reset_irq", {31'h0, irq}, 32'h0);
    chk("reset_done", {31'h0, bus.ctrl_done}, 32'h0);
    chk("reset_rdat", bus.ctrl_rdat, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) rd(addrs[i], 32'h0, $sformatf("reset_read_%02h", addrs[i]));
    wr(8'h40, 32'hDEAD_BEEF, "wr_unmapped");
    rd(8'h40, 32'h0, "rd_unmapped");

    // Simultaneous write+read returns the pre-write value.
    acc(1'b1, 1'b1, GPIO_FALL_EN, 32'h0000_00F0, 1'b1, 32'h0, "wr_rd_prewrite");
    rd(GPIO_FALL_EN, 32'hF0, "fall_en_rb");
    wr(GPIO_FALL_EN, 32'h0, "fall_en_clr");

    tb_drv = 8'h5A;
    repeat (3) @(negedge clk);
    rd(GPIO_DATA, 32'h5A, "data_in");
    tb_drv = 8'h00;
    repeat (3) @(negedge clk);

    // Output path: 0x0F |0x30 =0x3F, &~0x03 =0x3C, ^0x81 =0xBD.
    tb_en = 8'h00;
    wr(GPIO_DIR, 32'hFFFF_FFFF, "dir_all");
    rd(GPIO_DIR, 32'hFF, "dir_mask");
    wr(GPIO_DATA, 32'h0F, "data_wr");
    wr(GPIO_SET, 32'h30, "set");
    wr(GPIO_CLR, 32'h03, "clr");
    wr(GPIO_TGL, 32'h81, "tgl");
    rd(GPIO_OUT, 32'hBD, "out_rb");
    rd(GPIO_SET, 32'hBD, "set_rb");
    chk("pins_out", {24'h0, pins}, 32'hBD);
    repeat (3) @(negedge clk);
    rd(GPIO_DATA, 32'hBD, "data_loopback");
    rd(GPIO_STATUS, 32'h0, "status_quiet");
    wr(GPIO_DIR, 32'h0, "dir_off");
    @(negedge clk);
    tb_en = 8'hFF; tb_drv = 8'h00;
    repeat (4) @(negedge clk);

    // Rising edge: STATUS after 3 edges, irq after 4.
    wr(GPIO_RISE_EN, 32'h1, "rise_en");
    chk("irq_idle", {31'h0, irq}, 32'h0);
    tb_drv[0] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("irq_rise_t%0d", k), {31'h0, irq}, {31'h0, k == 4});
    end
    @(negedge clk);
    rd(GPIO_STATUS, 32'h1, "status_rise");

    tb_drv[0] = 1'b0;
    repeat (5) @(negedge clk);
    rd(GPIO_STATUS, 32'h1, "status_fall_dis");

    // W1C lands on the same edge as a new rise on pin 0.
    tb_drv[0] = 1'b1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    wr(GPIO_STATUS, 32'h1, "w1c_conflict");
    chk("irq_conflict_0", {31'h0, irq}, 32'h1);
    @(negedge clk);
    chk("irq_conflict_1", {31'h0, irq}, 32'h1);
    rd(GPIO_STATUS, 32'h1, "status_conflict");

    wr(GPIO_STATUS, 32'h1, "w1c");
    chk("irq_w1c_done", {31'h0, irq}, 32'h1);
    @(negedge clk);
    chk("irq_w1c_after", {31'h0, irq}, 32'h0);
    rd(GPIO_STATUS, 32'h0, "status_cleared");

    wr(GPIO_FALL_EN, 32'h1, "fall_en");
    tb_drv[0] = 1'b0;
    repeat (5) @(negedge clk);
    rd(GPIO_STATUS, 32'h1, "status_fall");
    wr(GPIO_FALL_EN, 32'h0, "fall_en_off");
    rd(GPIO_STATUS, 32'h1, "status_sticky");
    chk("irq_sticky", {31'h0, irq}, 32'h1);

    // Reset during a pending write, with pin 0 held high through release.
    tb_drv[0] = 1'b1;
    bus.ctrl_wr = 1'b1; bus.ctrl_addr = GPIO_RISE_EN; bus.ctrl_wdat = 32'hFF;
    #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_done", {31'h0, bus.ctrl_done}, 32'h0);
    bus.ctrl_wr = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b0;
    chk("rst_rel_done", {31'h0, bus.ctrl_done}, 32'h0);
    wr(GPIO_RISE_EN, 32'h1, "arm_rise_en");
    repeat (6) @(negedge clk);
    rd(GPIO_STATUS, 32'h0, "status_armed");
    chk("irq_armed", {31'h0, irq}, 32'h0);
    rd(GPIO_RISE_EN, 32'h1, "rise_en_after_rst");
    rd(GPIO_DIR, 32'h0, "dir_after_rst");

    tb_drv[0] = 1'b0;
    repeat (4) @(negedge clk);
    tb_drv[0] = 1'b1;
    repeat (5) @(negedge clk);
    rd(GPIO_STATUS, 32'h1, "status_post_arm");

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    chk("done_count", 32'(n_done), 32'(n_push));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
